// File: rtl/sm4_pkg.sv
// Shared SM4 constants: block width, decrypt core latency and error bit positions.
package sm4_pkg;
  localparam int SM4_BLK_W       = 128;
  localparam int SM4_DEC_LATENCY = 193;
  localparam int ERR_OVF         = 0;
  localparam int ERR_UNF         = 1;
  localparam int ERR_W           = 2;
endpackage

// File: rtl/sm4_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata shows the head whenever !empty.
module sm4_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sm4_cbc_dec_post.sv
// CBC decrypt post-processor: queues per-block masks at core input, XORs them onto the
// core's in-order plaintext, and buffers results behind a credit-limited AXI-stream port.
module sm4_cbc_dec_post
  import sm4_pkg::*;
#(
  parameter int                   P_DEPTH      = 256,
  parameter logic [SM4_BLK_W-1:0] P_DEFAULT_IV = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SM4_BLK_W-1:0] i_iv,
  input  logic                 i_iv_valid,
  input  logic                 i_ecb_mode,
  input  logic [SM4_BLK_W-1:0] i_ct_data,
  input  logic                 i_ct_fire,
  input  logic [SM4_BLK_W-1:0] i_pt_data,
  input  logic                 i_pt_valid,
  output logic                 o_ct_allow,
  output logic [SM4_BLK_W-1:0] o_axim_data,
  output logic                 o_axim_valid,
  input  logic                 i_axim_ready,
  output logic [ERR_W-1:0]     o_err
);
  localparam int CW = $clog2(P_DEPTH) + 1;

  logic [SM4_BLK_W-1:0] chain;
  logic [SM4_BLK_W-1:0] mask;
  logic [SM4_BLK_W-1:0] mask_head;
  logic [SM4_BLK_W-1:0] xor_data;
  logic [SM4_BLK_W-1:0] out_head;
  logic                 xor_valid;
  logic                 mask_full;
  logic                 mask_empty;
  logic                 out_full;
  logic                 out_empty;
  logic [CW-1:0]        mask_cnt;
  logic [CW-1:0]        out_cnt;
  logic [CW-1:0]        credit;
  logic                 at_limit;
  logic                 mask_pop;
  logic                 out_fire;
  logic                 unused_status;

  // Output stream: a word transfers on a cycle where o_axim_valid && i_axim_ready; while
  // valid is high and ready low the word is held. Credit returns only on that transfer.
  assign o_axim_valid = !out_empty;
  assign o_axim_data  = out_empty ? '0 : out_head;
  assign out_fire     = o_axim_valid && i_axim_ready;

  assign at_limit   = (credit == CW'(P_DEPTH));
  assign o_ct_allow = !at_limit;
  assign mask_pop   = i_pt_valid && !mask_empty;

  always_comb begin
    mask = chain;
    if (i_iv_valid) mask = i_iv;
    if (i_ecb_mode) mask = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chain     <= P_DEFAULT_IV;
      credit    <= '0;
      o_err     <= '0;
      xor_valid <= 1'b0;
      xor_data  <= '0;
    end else begin
      if (i_ct_fire)       chain <= i_ct_data;
      else if (i_iv_valid) chain <= i_iv;

      if (i_ct_fire && !out_fire && !at_limit)           credit <= credit + 1'b1;
      else if (!i_ct_fire && out_fire && credit != '0)   credit <= credit - 1'b1;

      if (i_ct_fire && (at_limit || mask_full)) o_err[ERR_OVF] <= 1'b1;
      if (i_pt_valid && mask_empty)             o_err[ERR_UNF] <= 1'b1;

      xor_valid <= mask_pop;
      if (mask_pop) xor_data <= i_pt_data ^ mask_head;
    end
  end

  sm4_sync_fifo #(.WIDTH(SM4_BLK_W), .DEPTH(P_DEPTH)) u_mask_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_ct_fire),
    .wdata (mask),
    .pop   (mask_pop),
    .rdata (mask_head),
    .full  (mask_full),
    .empty (mask_empty),
    .count (mask_cnt)
  );

  sm4_sync_fifo #(.WIDTH(SM4_BLK_W), .DEPTH(P_DEPTH)) u_out_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (xor_valid),
    .wdata (xor_data),
    .pop   (out_fire),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_cnt)
  );

  // Occupancy is bounded by the credit counter, so the FIFO status outputs are informational.
  assign unused_status = ^{mask_cnt, out_cnt, out_full};
endmodule

// File: tb/tb_sm4_cbc_dec_post.sv
// Scoreboard bench for sm4_cbc_dec_post: a mask/chain model predicts each plaintext word.
module tb_sm4_cbc_dec_post;
  localparam int          DEPTH      = 256;
  localparam int          LAT        = 193;
  localparam logic [127:0] DEFAULT_IV = 128'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] iv_in = '0;
  logic         iv_valid = 1'b0;
  logic         ecb_mode = 1'b0;
  logic [127:0] ct_data = '0;
  logic         ct_fire = 1'b0;
  logic [127:0] pt_data = '0;
  logic         pt_valid = 1'b0;
  logic         ct_allow;
  logic [127:0] axim_data;
  logic         axim_valid;
  logic         axim_ready = 1'b1;
  logic [1:0]   err;

  logic [127:0] exp_q[$];
  logic [127:0] mask_q[$];
  logic [127:0] chain_m = DEFAULT_IV;
  int           n_checks = 0;
  int           n_fail = 0;

  sm4_cbc_dec_post #(.P_DEPTH(DEPTH), .P_DEFAULT_IV(DEFAULT_IV)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_iv         (iv_in),
    .i_iv_valid   (iv_valid),
    .i_ecb_mode   (ecb_mode),
    .i_ct_data    (ct_data),
    .i_ct_fire    (ct_fire),
    .i_pt_data    (pt_data),
    .i_pt_valid   (pt_valid),
    .o_ct_allow   (ct_allow),
    .o_axim_data  (axim_data),
    .o_axim_valid (axim_valid),
    .i_axim_ready (axim_ready),
    .o_err        (err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted output word is popped against the expected queue.
  always @(negedge clk) begin
    if (!rst && axim_valid && axim_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h, expected no word", axim_data);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (axim_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %h, expected %h", axim_data, e);
        end
      end
    end
  end

  // Driver tasks: called 1ns after a rising edge, return 1ns after the next one.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ct_fire = 1'b0; pt_valid = 1'b0; iv_valid = 1'b0; ecb_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mask_q.delete();
    exp_q.delete();
    chain_m = DEFAULT_IV;
  endtask

  task automatic load_iv(input logic [127:0] iv);
    iv_in = iv; iv_valid = 1'b1;
    chain_m = iv;
    @(posedge clk); #1;
    iv_valid = 1'b0;
  endtask

  task automatic fire_ct(input logic [127:0] ct, input logic ecb, input logic ivv,
                         input logic [127:0] iv);
    logic [127:0] m;
    m = ecb ? 128'h0 : (ivv ? iv : chain_m);
    mask_q.push_back(m);
    chain_m = ct;
    ct_data = ct; ct_fire = 1'b1; ecb_mode = ecb; iv_valid = ivv; iv_in = iv;
    @(posedge clk); #1;
    ct_fire = 1'b0; ecb_mode = 1'b0; iv_valid = 1'b0;
  endtask

  task automatic drive_pt(input logic [127:0] pt, input bit use_exp, input logic [127:0] exp_v);
    logic [127:0] m;
    if (mask_q.size() > 0) begin
      m = mask_q.pop_front();
      exp_q.push_back(use_exp ? exp_v : (pt ^ m));
    end
    pt_data = pt; pt_valid = 1'b1;
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || axim_valid) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || axim_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still expected, valid=%b, required 0 and 0",
               name, exp_q.size(), axim_valid);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scenario tasks
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (axim_valid !== 1'b0 || axim_data !== 128'h0 || err !== 2'b00 || ct_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h err=%b allow=%b, required 0 0 00 1",
               axim_valid, axim_data, err, ct_allow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cbc_first();
    logic [127:0] iv, c1, pt, res;
    iv  = 128'h000102030405060708090a0b0c0d0e0f;
    c1  = 128'h681edf34d206965e86b3e94f536e4246;
    pt  = 128'h0123456789abcdeffedcba9876543210;
    res = 128'h012247648daecbe8f6d5b0937a593c1f;
    axim_ready = 1'b1;
    load_iv(iv);
    fire_ct(c1, 1'b0, 1'b0, '0);
    idle(3);
    drive_pt(pt, 1'b1, res);
    @(negedge clk);
    n_checks++;
    if (axim_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cbc_latency_t1: valid=%b, required 0", axim_valid);
    end
    @(negedge clk);
    n_checks++;
    if (axim_valid !== 1'b1 || axim_data !== res) begin
      n_fail++;
      $display("FAIL cbc_latency_t2: valid=%b data=%h, required 1 %h", axim_valid, axim_data, res);
    end
    @(posedge clk); #1;
    wait_drain("cbc_first");
  endtask

  task automatic test_chain();
    fire_ct(rand128(), 1'b0, 1'b0, '0);
    drive_pt(128'h0, 1'b1, 128'h681edf34d206965e86b3e94f536e4246);
    wait_drain("chain");
  endtask

  task automatic test_ecb_iv();
    logic [127:0] pt, ones;
    pt   = 128'h0123456789abcdeffedcba9876543210;
    ones = '1;
    fire_ct(rand128(), 1'b1, 1'b0, '0);
    drive_pt(pt, 1'b1, pt);
    fire_ct(rand128(), 1'b0, 1'b1, ones);
    drive_pt(128'h0, 1'b1, ones);
    wait_drain("ecb_iv");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 16; i++)
          fire_ct(rand128(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), rand128());
      end
      begin
        idle(5);
        for (int i = 0; i < 16; i++) drive_pt(rand128(), 1'b0, '0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          axim_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
    join
    axim_ready = 1'b1;
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure();
    axim_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < DEPTH; i++) begin
          n_checks++;
          if (ct_allow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_allow_before_fire%0d: allow=%b, required 1", i, ct_allow);
          end
          fire_ct(rand128(), 1'b0, 1'b0, '0);
        end
        n_checks++;
        if (ct_allow !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_allow_after_last: allow=%b, required 0", ct_allow);
        end
      end
      begin
        idle(LAT);
        for (int i = 0; i < DEPTH; i++) drive_pt(rand128(), 1'b0, '0);
      end
    join
    idle(4);
    n_checks++;
    if (ct_allow !== 1'b0 || err !== 2'b00 || axim_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full_state: allow=%b err=%b valid=%b, required 0 00 1",
               ct_allow, err, axim_valid);
    end
    axim_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ct_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_allow_first_pop: allow=%b, required 1", ct_allow);
    end
    @(posedge clk); #1;
    wait_drain("backpressure");
  endtask

  task automatic test_errors();
    reset_dut();
    axim_ready = 1'b0;
    drive_pt(rand128(), 1'b0, '0);
    idle(1);
    n_checks++;
    if (err !== 2'b10) begin
      n_fail++;
      $display("FAIL err_underflow: err=%b, required 10", err);
    end
    for (int i = 0; i < DEPTH; i++) fire_ct(rand128(), 1'b0, 1'b0, '0);
    n_checks++;
    if (ct_allow !== 1'b0 || err !== 2'b10) begin
      n_fail++;
      $display("FAIL err_at_limit: allow=%b err=%b, required 0 10", ct_allow, err);
    end
    fire_ct(rand128(), 1'b0, 1'b0, '0);
    idle(1);
    n_checks++;
    if (err !== 2'b11) begin
      n_fail++;
      $display("FAIL err_overflow: err=%b, required 11", err);
    end
    idle(5);
    n_checks++;
    if (err !== 2'b11) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, required 11", err);
    end
    reset_dut();
    @(negedge clk);
    n_checks++;
    if (err !== 2'b00 || ct_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cleared: err=%b allow=%b, required 00 1", err, ct_allow);
    end
    @(posedge clk); #1;
    axim_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    axim_ready = 1'b0;
    load_iv(rand128());
    for (int i = 0; i < 10; i++) fire_ct(rand128(), 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) drive_pt(rand128(), 1'b0, '0);
    idle(3);
    n_checks++;
    if (axim_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: valid=%b, required 1", axim_valid);
    end
    reset_dut();
    @(negedge clk);
    n_checks++;
    if (axim_valid !== 1'b0 || ct_allow !== 1'b1 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_post: valid=%b allow=%b err=%b, required 0 1 00",
               axim_valid, ct_allow, err);
    end
    @(posedge clk); #1;
    axim_ready = 1'b1;
    pt = 128'hdeadbeef_00112233_44556677_8899aabb;
    fire_ct(rand128(), 1'b0, 1'b0, '0);
    drive_pt(pt, 1'b1, pt ^ DEFAULT_IV);
    wait_drain("rst_mid");
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    reset_dut();
    test_reset();
    test_cbc_first();
    test_chain();
    test_ecb_iv();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
